mod_exp_core: RTL and testbench
===============================

# mod_exp_core

Word-serial RSA modular exponentiation engine computing m^e mod n with radix-2 Montgomery multiplication, for the decryption datapath.
- Generalises the fixed 64-bit Montgomery product block to a parametrised operand length K = WORD_W*NUM_WORDS.
- Operands stream in one word per beat; the result streams out one word per beat. Both streams use valid/ready handshakes.
- Adds host-supplied R^2 conversion, odd-modulus checking and a selectable fixed-latency or fast exponent scan.

## Interface
- WORD_W, 64, bits per streamed word
- NUM_WORDS, 16, words per operand; K = WORD_W*NUM_WORDS (1024 by default), R = 2^K
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  high in LOAD; reset value 1
- in_n, in_e, in_m, in_r2  in  WORD_W each  modulus, exponent, message, R^2 mod n; one word of each per beat, least-significant word first
- out_valid  out  1  result beat valid; reset 0
- out_ready  in  1  sink accepts beat
- out_data  out  WORD_W  result word, LS first; reset 0
- out_last  out  1  final result beat; reset 0
- out_err  out  1  set on every beat of an errored result (n even); reset 0
- busy  out  1  high from the last input beat accepted until the last output beat accepted; reset 0

## Operation
- Beat transfer: a beat transfers when valid & ready are both high on a rising edge.
- LOAD: NUM_WORDS beats are shifted into the K-bit n/e/m/r2 registers through a word counter. After the last beat, go to CHECK.
- CHECK (1 cycle): if n[0]==0, raise the error flag and go to OUT with result 0. Otherwise go to CONV_M.
- CONV_M: mbar = MonPro(m, r2).
- CONV_X: xbar = MonPro(1, r2).
- EXP: scans e from bit K-1 down to bit 0. For each bit:
  - SQR: xbar = MonPro(xbar, xbar).
  - MUL: t = MonPro(mbar, xbar); xbar = t only if the bit is 1. Without the macro below, MUL is always executed.
- FINAL: x = MonPro(xbar, 1), then go to OUT.
- OUT: NUM_WORDS beats of x, LS first. out_last is set on beat NUM_WORDS-1. After the last beat is accepted, return to LOAD.
- MonPro(a,b) = a*b*R^-1 mod n, computed radix-2 bit-serially:
  - K iterations; iteration i: s = (s + a_i*b + q*n)/2, with q = (s + a_i*b)[0].
  - The accumulator is K+2 bits wide.
  - One conditional subtraction of n at the end gives a result < n.
- Input rules: requires m < n and r2 == R^2 mod n. If violated, the numeric result is undefined, but protocol and timing are unchanged.
- e == 0: result is 1 mod n, i.e. 1, or 0 when n == 1.
- Reset: asserting reset at any point, including mid-compute or mid-output, aborts immediately. All outputs return to their reset values, the FSM returns to LOAD and the word counter clears.

## Timing
- MonPro latency: done pulses exactly K+2 cycles after start is sampled (1 load cycle, K iterations, 1 subtraction). The FSM spends 1 dispatch cycle per product, so each product costs K+3 cycles.
- Fixed latency (macro absent): the first out_valid comes exactly L = (2K+3)(K+3)+2 cycles after the edge accepting the last input beat, independent of e and m.
- Error path: out_valid comes 2 cycles after the last input beat.
- Output stall: out_data, out_last and out_err hold stable while out_valid & !out_ready.
- Input blocking: in_ready stays low outside LOAD; input beats offered then are ignored.
- Back-to-back: the next LOAD beat can be accepted in the cycle after the out_last beat is accepted.

## Configuration
- MODEXP_FAST_EN defined:
  - Leading zero bits of e are skipped; each skipped bit costs 1 cycle.
  - MUL is omitted for zero bits.
  - Latency becomes data dependent.
- MODEXP_FAST_EN undefined: the constant-time schedule above, with latency L exactly.
- Both builds give bit-identical results.

## Structure
- Shared package mod_exp_pkg holds:
  - FSM state enum: LOAD, CHECK, CONV_M, CONV_X, SQR, MUL, FINAL, OUT.
  - K derivation and the default WORD_W/NUM_WORDS localparams.
- Sub-module mont_mul (parameter K):
  - Inputs: start, a, b, n.
  - Outputs: done, res.
  - Internals: bit-serial Montgomery product with an iteration counter.
- mod_exp_core contains the load/unload shifters, the exponent bit counter and the top FSM.

## Test plan
Benches use WORD_W=8, NUM_WORDS=2 (K=16).
1. n=0x0011, e=0x0005, m=0x0003, r2=0x0001 -> result 0x0005, out_err=0, first out_valid 667 cycles after the last input beat (macro absent).
2. n=0xFFF1, e=0x0010, m=0x0002, r2=0x00E1 -> result 0x000F; latency again 667. With MODEXP_FAST_EN, same result and strictly lower latency.
3. n=0xFFF1, e=0x0000, m=0x1234, r2=0x00E1 -> result 0x0001.
4. n=0x0010 (even) -> out_err=1 on both beats, data 0x00,0x00, out_valid 2 cycles after the last input beat, no MonPro activity.
5. Random out_ready stalls during case 1 -> beats 0x05 then 0x00 in order, held stable while stalled, out_last only on beat 2. in_valid pulses offered during compute are ignored.
6. reset asserted 100 cycles into compute, released, then case 2 loaded -> all outputs at reset values during reset; correct 0x000F afterwards.

Source files
------------

// File: rtl/mod_exp_pkg.sv
// Shared types and sizing for the modular exponentiation engine.
// Optional feature macro used by mod_exp_core: MODEXP_FAST_EN.
package mod_exp_pkg;

    localparam int DEF_WORD_W    = 64;
    localparam int DEF_NUM_WORDS = 16;

    // Operand length K in bits; R = 2^K.
    function automatic int calc_k(input int word_w, input int num_words);
        return word_w * num_words;
    endfunction

    // Top-level sequencing states.
    typedef enum logic [2:0] {
        LOAD,
        CHECK,
        CONV_M,
        CONV_X,
        SQR,
        MUL,
        FINAL,
        OUT
    } state_t;

    // Montgomery multiplier phases.
    typedef enum logic [1:0] {
        MM_IDLE,
        MM_ITER,
        MM_SUB
    } mm_phase_t;

endpackage

// File: rtl/mod_exp_core_mont_mul.sv
// Bit-serial radix-2 Montgomery product: res = a*b*R^-1 mod n, R = 2^K.
// Start is sampled into a load cycle, followed by K iterations and one
// conditional subtraction; done pulses for one cycle with res valid.
module mont_mul
    import mod_exp_pkg::*;
#(
    parameter int K = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic [K-1:0] n,
    output logic         done,
    output logic [K-1:0] res
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;

    mm_phase_t    phase;
    logic [K-1:0] a_sh;
    logic [K-1:0] b_r;
    logic [K-1:0] n_r;
    logic [K+1:0] acc;
    logic [K+1:0] acc_add;
    logic [K+1:0] acc_next;
    logic [K+1:0] acc_diff;
    logic [CW-1:0] iter;

    // One radix-2 step: add a_i*b, add q*n to make the sum even, then halve.
    // NOTE: every variable driven here is assigned on every path, so no latch is inferred.
    always_comb begin
        acc_add  = acc + (a_sh[0] ? {2'b00, b_r} : '0);
        acc_next = (acc_add + (acc_add[0] ? {2'b00, n_r} : '0)) >> 1;
        acc_diff = acc - {2'b00, n_r};
    end

    // Iteration sequencer; a new start always restarts from the load cycle.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= MM_IDLE;
            a_sh  <= '0;
            b_r   <= '0;
            n_r   <= '0;
            acc   <= '0;
            iter  <= '0;
            done  <= 1'b0;
            res   <= '0;
        end else begin
            done <= 1'b0;
            case (phase)
                MM_ITER: begin
                    acc  <= acc_next;
                    a_sh <= a_sh >> 1;
                    iter <= iter + 1'b1;
                    if (iter == CW'(K - 1)) phase <= MM_SUB;
                end
                MM_SUB: begin
                    res   <= (acc >= {2'b00, n_r}) ? acc_diff[K-1:0] : acc[K-1:0];
                    done  <= 1'b1;
                    phase <= MM_IDLE;
                end
                default: phase <= MM_IDLE;
            endcase
            if (start) begin
                a_sh  <= a;
                b_r   <= b;
                n_r   <= n;
                acc   <= '0;
                iter  <= '0;
                phase <= MM_ITER;
            end
        end
    end

endmodule

// File: rtl/mod_exp_core.sv
// Word-serial RSA modular exponentiation m^e mod n using Montgomery products.
// Operands stream in LS word first; the result streams out LS word first.
// Macro MODEXP_FAST_EN: skip leading zero exponent bits and omit MUL on zero
// bits (data-dependent latency). Undefined: constant-time schedule.
module mod_exp_core
    import mod_exp_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_n,
    input  logic [WORD_W-1:0] in_e,
    input  logic [WORD_W-1:0] in_m,
    input  logic [WORD_W-1:0] in_r2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              out_err,
    output logic              busy
);

    localparam int K   = calc_k(WORD_W, NUM_WORDS);
    localparam int WCW = $clog2(NUM_WORDS + 1);
    localparam int BCW = (K > 1) ? $clog2(K) : 1;
    localparam logic [K-1:0] ONE_K = K'(1);

    state_t         state;
    logic [K-1:0]   n_r;
    logic [K-1:0]   e_r;
    logic [K-1:0]   m_r;
    logic [K-1:0]   r2_r;
    logic [K-1:0]   mbar;
    logic [K-1:0]   xbar;
    logic [K-1:0]   x_r;
    logic [WCW-1:0] word_cnt;
    logic [BCW-1:0] bit_cnt;
    logic           issued;
    logic           err_r;
`ifdef MODEXP_FAST_EN
    logic           lead_zero;
`endif

    logic [K-1:0]   mm_a;
    logic [K-1:0]   mm_b;
    logic [K-1:0]   mm_res;
    logic           mm_done;
    logic           mm_start;
    logic           is_prod;
    logic           skip_bit;

    // New word enters at the top; after NUM_WORDS beats the first word sits at the bottom.
    function automatic logic [K-1:0] push_word(input logic [K-1:0] cur,
                                               input logic [WORD_W-1:0] w);
        logic [K+WORD_W-1:0] cat;
        cat = {w, cur};
        return cat[K+WORD_W-1:WORD_W];
    endfunction

    // Operand selection for the product of the current state.
    always_comb begin
        mm_a = m_r;
        mm_b = r2_r;
        case (state)
            CONV_X: begin mm_a = ONE_K; mm_b = r2_r;  end
            SQR:    begin mm_a = xbar;  mm_b = xbar;  end
            MUL:    begin mm_a = mbar;  mm_b = xbar;  end
            FINAL:  begin mm_a = xbar;  mm_b = ONE_K; end
            default: ;
        endcase
    end

    // Product dispatch: one start per product state, unless the bit is skipped.
    always_comb begin
        is_prod  = (state == CONV_M) || (state == CONV_X) || (state == SQR) ||
                   (state == MUL) || (state == FINAL);
        skip_bit = 1'b0;
`ifdef MODEXP_FAST_EN
        skip_bit = (state == SQR) && lead_zero && !e_r[bit_cnt];
`endif
        mm_start = is_prod && !issued && !skip_bit;
    end

    mont_mul #(.K(K)) u_mm (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .n     (n_r),
        .done  (mm_done),
        .res   (mm_res)
    );

    // Top FSM: load shifters, modulus check, exponent scan and result unload.
    // NOTE: the wide operand registers are plain flops, so they share the async reset with the control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            n_r       <= '0;
            e_r       <= '0;
            m_r       <= '0;
            r2_r      <= '0;
            mbar      <= '0;
            xbar      <= '0;
            x_r       <= '0;
            word_cnt  <= '0;
            bit_cnt   <= '0;
            issued    <= 1'b0;
            err_r     <= 1'b0;
`ifdef MODEXP_FAST_EN
            lead_zero <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        n_r  <= push_word(n_r, in_n);
                        e_r  <= push_word(e_r, in_e);
                        m_r  <= push_word(m_r, in_m);
                        r2_r <= push_word(r2_r, in_r2);
                        if (word_cnt == WCW'(NUM_WORDS - 1)) begin
                            word_cnt <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= CHECK;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    bit_cnt <= BCW'(K - 1);
                    issued  <= 1'b0;
`ifdef MODEXP_FAST_EN
                    lead_zero <= 1'b1;
`endif
                    if (!n_r[0]) begin
                        err_r <= 1'b1;
                        x_r   <= '0;
                        state <= OUT;
                    end else begin
                        err_r <= 1'b0;
                        state <= CONV_M;
                    end
                end
                CONV_M, CONV_X, SQR, MUL, FINAL: begin
                    if (mm_start) begin
                        issued <= 1'b1;
`ifdef MODEXP_FAST_EN
                        if (state == SQR) lead_zero <= 1'b0;
`endif
                    end else if (skip_bit) begin
                        if (bit_cnt == '0) state <= FINAL;
                        else               bit_cnt <= bit_cnt - 1'b1;
                    end else if (issued && mm_done) begin
                        issued <= 1'b0;
                        case (state)
                            CONV_M: begin
                                mbar  <= mm_res;
                                state <= CONV_X;
                            end
                            CONV_X: begin
                                xbar  <= mm_res;
                                state <= SQR;
                            end
                            SQR: begin
                                xbar <= mm_res;
`ifdef MODEXP_FAST_EN
                                if (e_r[bit_cnt])       state <= MUL;
                                else if (bit_cnt == '0) state <= FINAL;
                                else                    bit_cnt <= bit_cnt - 1'b1;
`else
                                state <= MUL;
`endif
                            end
                            MUL: begin
                                if (e_r[bit_cnt]) xbar <= mm_res;
                                if (bit_cnt == '0) begin
                                    state <= FINAL;
                                end else begin
                                    bit_cnt <= bit_cnt - 1'b1;
                                    state   <= SQR;
                                end
                            end
                            default: begin
                                x_r   <= mm_res;
                                state <= OUT;
                            end
                        endcase
                    end
                end
                OUT: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_err   <= 1'b0;
                            out_data  <= '0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            word_cnt  <= '0;
                            err_r     <= 1'b0;
                            state     <= LOAD;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= x_r[WORD_W-1:0];
                            x_r       <= x_r >> WORD_W;
                            out_last  <= (word_cnt == WCW'(NUM_WORDS - 1));
                            out_err   <= err_r;
                            word_cnt  <= word_cnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_core.sv
// Self-checking bench for mod_exp_core with WORD_W=8, NUM_WORDS=2 (K=16).
// Results are predicted by square-and-multiply on plain integers.
module tb_mod_exp_core;

    localparam int WORD_W    = 8;
    localparam int NUM_WORDS = 2;
    localparam int K         = WORD_W * NUM_WORDS;
    localparam int LAT       = (2 * K + 3) * (K + 3) + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_n = '0;
    logic [WORD_W-1:0] in_e = '0;
    logic [WORD_W-1:0] in_m = '0;
    logic [WORD_W-1:0] in_r2 = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              out_err;
    logic              busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    mod_exp_core #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n      (in_n),
        .in_e      (in_e),
        .in_m      (in_m),
        .in_r2     (in_r2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // m^e mod n by square-and-multiply; an even modulus yields 0.
    function automatic logic [K-1:0] model_modexp(input logic [K-1:0] n,
                                                  input logic [K-1:0] e,
                                                  input logic [K-1:0] m);
        longint unsigned md, r, base;
        if (n[0] == 1'b0) return '0;
        md   = longint'(n);
        r    = 1 % md;
        base = longint'(m) % md;
        for (int i = 0; i < K; i++) begin
            if (e[i]) r = (r * base) % md;
            base = (base * base) % md;
        end
        return K'(r);
    endfunction

    function automatic logic [K-1:0] model_r2(input logic [K-1:0] n);
        longint unsigned r;
        r = (64'd1 << (2 * K)) % longint'(n);
        return K'(r);
    endfunction

    task automatic send_op(input logic [K-1:0] n, input logic [K-1:0] e,
                           input logic [K-1:0] m, input logic [K-1:0] r2,
                           output int t_acc);
        int guard;
        for (int w = 0; w < NUM_WORDS; w++) begin
            in_valid = 1'b1;
            in_n  = n[w*WORD_W +: WORD_W];
            in_e  = e[w*WORD_W +: WORD_W];
            in_m  = m[w*WORD_W +: WORD_W];
            in_r2 = r2[w*WORD_W +: WORD_W];
            guard = 0;
            while (in_ready !== 1'b1 && guard < 1000) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 1000) check("in_ready_timeout", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        t_acc = cyc;
    endtask

    // Waits for the first result beat; optionally offers junk input beats meanwhile.
    task automatic wait_valid(input string tag, input bit noise, output int t_v);
        int guard;
        guard = 0;
        check({tag, ":in_ready_low"}, in_ready, 0);
        while (out_valid !== 1'b1 && guard < LAT + 200) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_n  = WORD_W'($urandom);
                in_e  = WORD_W'($urandom);
                in_m  = WORD_W'($urandom);
                in_r2 = WORD_W'($urandom);
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (out_valid !== 1'b1) check({tag, ":out_valid_timeout"}, out_valid, 1);
        t_v = cyc;
    endtask

    task automatic recv(input string tag, input logic [K-1:0] exp,
                        input bit exp_err, input bit stall);
        logic [WORD_W-1:0] ew;
        int guard, n_st;
        for (int b = 0; b < NUM_WORDS; b++) begin
            ew = exp[b*WORD_W +: WORD_W];
            guard = 0;
            while (out_valid !== 1'b1 && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            if (out_valid !== 1'b1) check({tag, ":beat_timeout"}, out_valid, 1);
            if (stall) begin
                n_st = $urandom_range(1, 3);
                for (int s = 0; s < n_st; s++) begin
                    @(posedge clk); #1;
                    check({tag, ":stall_valid"}, out_valid, 1);
                    check({tag, ":stall_data"}, out_data, ew);
                    check({tag, ":stall_last"}, out_last, (b == NUM_WORDS - 1));
                end
            end
            check({tag, ":data"}, out_data, ew);
            check({tag, ":last"}, out_last, (b == NUM_WORDS - 1));
            check({tag, ":err"}, out_err, exp_err);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check({tag, ":done_valid"}, out_valid, 0);
        check({tag, ":done_busy"}, busy, 0);
        check({tag, ":b2b_ready"}, in_ready, 1);
    endtask

    task automatic run_case(input string tag, input logic [K-1:0] n, input logic [K-1:0] e,
                            input logic [K-1:0] m, input logic [K-1:0] r2,
                            input bit stall, input bit noise, output int lat);
        logic [K-1:0] exp;
        int t_acc, t_v;
        exp = model_modexp(n, e, m);
        send_op(n, e, m, r2, t_acc);
        check({tag, ":busy"}, busy, 1);
        wait_valid(tag, noise, t_v);
        lat = t_v - t_acc;
        recv(tag, exp, !n[0], stall);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":in_ready"}, in_ready, 1);
        check({tag, ":out_valid"}, out_valid, 0);
        check({tag, ":out_data"}, out_data, 0);
        check({tag, ":out_last"}, out_last, 0);
        check({tag, ":out_err"}, out_err, 0);
        check({tag, ":busy"}, busy, 0);
    endtask

    initial begin
        int lat, t_acc;
        logic [K-1:0] rn, re, rm;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        @(posedge clk); #1;

        // Small modulus, basic exponent.
        run_case("c1", 16'h0011, 16'h0005, 16'h0003, 16'h0001, 0, 0, lat);
        check("c1:lat", lat, LAT);

        // Large modulus, sparse exponent.
        run_case("c2", 16'hFFF1, 16'h0010, 16'h0002, 16'h00E1, 0, 0, lat);
`ifdef MODEXP_FAST_EN
        check("c2:lat_fast_lower", (lat < LAT), 1);
`else
        check("c2:lat", lat, LAT);
`endif

        // Zero exponent gives 1, and 0 for a unit modulus.
        run_case("c3", 16'hFFF1, 16'h0000, 16'h1234, 16'h00E1, 0, 0, lat);
        run_case("c3n1", 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, 0, lat);

        // Even modulus takes the error path.
        run_case("c4", 16'h0010, 16'h0005, 16'h0003, 16'h0001, 0, 0, lat);
        check("c4:lat", lat, 2);

        // Output stalls and junk input beats during compute.
        run_case("c5", 16'h0011, 16'h0005, 16'h0003, 16'h0001, 1, 1, lat);
        check("c5:lat", lat, LAT);

        // Random odd moduli with valid r2 and m < n.
        for (int i = 0; i < 4; i++) begin
            rn = K'($urandom_range(3, 65535)) | 16'h0001;
            rm = K'($urandom_range(0, int'(rn) - 1));
            re = K'($urandom);
            run_case("rand", rn, re, rm, model_r2(rn), 1, 1, lat);
`ifdef MODEXP_FAST_EN
            check("rand:lat_fast", (lat <= LAT), 1);
`else
            check("rand:lat", lat, LAT);
`endif
        end

        // Reset in the middle of a computation, then a fresh operation.
        send_op(16'h0011, 16'h0005, 16'h0003, 16'h0001, t_acc);
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk); #1;
        check_reset_outputs("rst_held");
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        run_case("c6", 16'hFFF1, 16'h0010, 16'h0002, 16'h00E1, 0, 0, lat);
`ifndef MODEXP_FAST_EN
        check("c6:lat", lat, LAT);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
